// File: rtl/debug_bkp_pkg.sv
// Shared encodings for the debug register / breakpoint block.
// The optional single-step feature is controlled by DEBUG_SINGLE_STEP_EN (see debug_bkp_regs).
package debug_bkp_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_BREAK    = 2'd1,
    ST_HALTED   = 2'd2,
    ST_STEPOVER = 2'd3
  } dbg_state_e;

  localparam logic [2:0] BKP_IDX_STEP      = 3'd7;
  localparam int         ADDR_STEP_DEFAULT = 2;
  localparam int         NUM_BKP_DEFAULT   = 4;

endpackage

// File: rtl/debug_bkp_match.sv
// Combinational breakpoint comparator: reports whether any valid slot equals
// the PC and the lowest matching slot index.
module debug_bkp_match
  import debug_bkp_pkg::*;
#(
  parameter int NUM_BKP = NUM_BKP_DEFAULT
) (
  input  logic [15:0]        slot [NUM_BKP],
  input  logic [NUM_BKP-1:0] valid,
  input  logic [15:0]        pc,
  output logic               hit,
  output logic [2:0]         idx
);

  // Scan from the top down so the lowest matching index is the one left standing.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int i = NUM_BKP - 1; i >= 0; i--) begin
      if (valid[i] && (slot[i] == pc)) begin
        hit = 1'b1;
        idx = 3'(i);
      end
    end
  end

endmodule

// File: rtl/debug_bkp_regs.sv
// Debug-port address/argument/data registers, breakpoint table and the
// break/halt/resume handshake. Define DEBUG_SINGLE_STEP_EN to add the STEP input.
//
//   state     | meaning
//   ----------+----------------------------------------------------------
//   RUN       | CPU running, breakpoints armed
//   BREAK     | BREAK_REQ high, waiting for CPU_HALTED
//   HALTED    | CPU stopped, waiting for RESUME (or STEP)
//   STEPOVER  | next fetch is exempt from matching, then back to RUN
module debug_bkp_regs
  import debug_bkp_pkg::*;
#(
  parameter int NUM_BKP   = NUM_BKP_DEFAULT,
  parameter int ADDR_STEP = ADDR_STEP_DEFAULT
) (
  input  logic        CLK,
  input  logic        RESET,
`ifdef DEBUG_SINGLE_STEP_EN
  input  logic        STEP,
`endif
  input  logic        DEBUG_ADDR_INC_EN,
  input  logic        DEBUG_LD_DATA_EN,
  input  logic        DEBUG_LD_ARG_EN,
  input  logic        DEBUG_LD_BKP_EN,
  input  logic        BKP_CLR,
  input  logic [15:0] HOST_ARG_IN,
  input  logic [15:0] MEM_DATA_IN,
  input  logic        CPU_FETCH,
  input  logic [15:0] CPU_PC,
  input  logic        CPU_HALTED,
  input  logic        RESUME,
  output logic [15:0] DBG_ADDR,
  output logic [15:0] DBG_ARG,
  output logic [15:0] DBG_DATA,
  output logic        BREAK_REQ,
  output logic [2:0]  BKP_HIT_IDX,
  output logic [1:0]  DBG_STATE
);

  logic [15:0]        slot [NUM_BKP];
  logic [NUM_BKP-1:0] valid;
  logic [2:0]         bkp_ptr;
  logic               match_hit;
  logic [2:0]         match_idx;
  dbg_state_e         state, state_nxt;
  logic [2:0]         hit_idx_nxt;
  logic               step_pend, step_pend_nxt;
  logic               step_req;

`ifdef DEBUG_SINGLE_STEP_EN
  assign step_req = STEP;
`else
  assign step_req = 1'b0;
`endif

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      DBG_ADDR <= '0;
      DBG_ARG  <= '0;
      DBG_DATA <= '0;
    end else begin
      if (DEBUG_LD_ARG_EN) begin
        DBG_ARG  <= HOST_ARG_IN;
        DBG_ADDR <= HOST_ARG_IN;
      end else if (DEBUG_ADDR_INC_EN) begin
        DBG_ADDR <= DBG_ADDR + 16'(ADDR_STEP);
      end
      if (DEBUG_LD_DATA_EN)
        DBG_DATA <= MEM_DATA_IN;
    end
  end

  // Slot select by compare loop keeps the pointer width independent of NUM_BKP.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      valid   <= '0;
      bkp_ptr <= '0;
      for (int i = 0; i < NUM_BKP; i++)
        slot[i] <= '0;
    end else if (BKP_CLR) begin
      valid   <= '0;
      bkp_ptr <= '0;
    end else if (DEBUG_LD_BKP_EN) begin
      for (int i = 0; i < NUM_BKP; i++) begin
        if (bkp_ptr == 3'(i)) begin
          slot[i]  <= DBG_ARG;
          valid[i] <= 1'b1;
        end
      end
      bkp_ptr <= (bkp_ptr == 3'(NUM_BKP - 1)) ? 3'd0 : bkp_ptr + 3'd1;
    end
  end

  debug_bkp_match #(.NUM_BKP(NUM_BKP)) u_match (
    .slot  (slot),
    .valid (valid),
    .pc    (CPU_PC),
    .hit   (match_hit),
    .idx   (match_idx)
  );

  always_comb begin
    state_nxt     = state;
    hit_idx_nxt   = BKP_HIT_IDX;
    step_pend_nxt = step_pend;
    case (state)
      ST_RUN: begin
        if (CPU_FETCH && step_pend) begin
          state_nxt     = ST_BREAK;
          hit_idx_nxt   = BKP_IDX_STEP;
          step_pend_nxt = 1'b0;
        end else if (CPU_FETCH && match_hit) begin
          state_nxt   = ST_BREAK;
          hit_idx_nxt = match_idx;
        end
      end
      ST_BREAK: begin
        if (CPU_HALTED)
          state_nxt = ST_HALTED;
      end
      ST_HALTED: begin
        if (RESUME) begin
          state_nxt     = ST_STEPOVER;
          step_pend_nxt = 1'b0;
        end else if (step_req) begin
          state_nxt     = ST_STEPOVER;
          step_pend_nxt = 1'b1;
        end
      end
      ST_STEPOVER: begin
        // A pending single step survives this exempt fetch and fires on the next one.
        if (CPU_FETCH)
          state_nxt = ST_RUN;
      end
      default: state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state       <= ST_RUN;
      BKP_HIT_IDX <= '0;
      step_pend   <= 1'b0;
    end else begin
      state       <= state_nxt;
      BKP_HIT_IDX <= hit_idx_nxt;
      step_pend   <= step_pend_nxt;
    end
  end

  assign BREAK_REQ = (state == ST_BREAK);
  assign DBG_STATE = state;

endmodule

// File: tb/tb_debug_bkp_regs.sv
// Scoreboard bench for debug_bkp_regs: a behavioural model predicts every
// cycle's outputs, a separate monitor compares them after each clock edge.
module tb_debug_bkp_regs;

  localparam int NB = 4;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        STEP;
  logic        DEBUG_ADDR_INC_EN, DEBUG_LD_DATA_EN, DEBUG_LD_ARG_EN, DEBUG_LD_BKP_EN, BKP_CLR;
  logic [15:0] HOST_ARG_IN, MEM_DATA_IN, CPU_PC;
  logic        CPU_FETCH, CPU_HALTED, RESUME;
  logic [15:0] DBG_ADDR, DBG_ARG, DBG_DATA;
  logic        BREAK_REQ;
  logic [2:0]  BKP_HIT_IDX;
  logic [1:0]  DBG_STATE;

  always #5 CLK = ~CLK;

  debug_bkp_regs #(.NUM_BKP(NB), .ADDR_STEP(2)) dut (
    .CLK               (CLK),
    .RESET             (RESET),
`ifdef DEBUG_SINGLE_STEP_EN
    .STEP              (STEP),
`endif
    .DEBUG_ADDR_INC_EN (DEBUG_ADDR_INC_EN),
    .DEBUG_LD_DATA_EN  (DEBUG_LD_DATA_EN),
    .DEBUG_LD_ARG_EN   (DEBUG_LD_ARG_EN),
    .DEBUG_LD_BKP_EN   (DEBUG_LD_BKP_EN),
    .BKP_CLR           (BKP_CLR),
    .HOST_ARG_IN       (HOST_ARG_IN),
    .MEM_DATA_IN       (MEM_DATA_IN),
    .CPU_FETCH         (CPU_FETCH),
    .CPU_PC            (CPU_PC),
    .CPU_HALTED        (CPU_HALTED),
    .RESUME            (RESUME),
    .DBG_ADDR          (DBG_ADDR),
    .DBG_ARG           (DBG_ARG),
    .DBG_DATA          (DBG_DATA),
    .BREAK_REQ         (BREAK_REQ),
    .BKP_HIT_IDX       (BKP_HIT_IDX),
    .DBG_STATE         (DBG_STATE)
  );

  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] arg;
    logic [15:0] data;
    logic        brk;
    logic [2:0]  idx;
    logic [1:0]  st;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model: mode 0 run, 1 break, 2 halted, 3 stepover.
  logic [15:0] m_addr, m_arg, m_data;
  logic [15:0] m_slot [NB];
  bit          m_valid [NB];
  int          m_ptr, m_mode, m_idx, m_step_left;

  task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
    end
  endtask

  task automatic model_reset();
    m_addr = 0; m_arg = 0; m_data = 0;
    m_ptr = 0; m_mode = 0; m_idx = 0; m_step_left = 0;
    for (int i = 0; i < NB; i++) begin
      m_slot[i]  = 0;
      m_valid[i] = 0;
    end
  endtask

  task automatic model_step();
    int hit_i;
    exp_t e;
    hit_i = -1;
    for (int i = 0; i < NB; i++)
      if (hit_i < 0 && m_valid[i] && m_slot[i] == CPU_PC) hit_i = i;
    case (m_mode)
      0: if (CPU_FETCH) begin
           if (m_step_left == 1) begin m_mode = 1; m_idx = 7; m_step_left = 0; end
           else if (hit_i >= 0) begin m_mode = 1; m_idx = hit_i; end
         end
      1: if (CPU_HALTED) m_mode = 2;
      2: if (RESUME) begin m_mode = 3; m_step_left = 0; end
         else if (STEP) begin m_mode = 3; m_step_left = 2; end
      default: if (CPU_FETCH) begin
           m_mode = 0;
           if (m_step_left > 0) m_step_left--;
         end
    endcase
    if (BKP_CLR) begin
      for (int i = 0; i < NB; i++) m_valid[i] = 0;
      m_ptr = 0;
    end else if (DEBUG_LD_BKP_EN) begin
      m_slot[m_ptr]  = m_arg;
      m_valid[m_ptr] = 1;
      m_ptr = (m_ptr + 1) % NB;
    end
    if (DEBUG_LD_ARG_EN) begin m_arg = HOST_ARG_IN; m_addr = HOST_ARG_IN; end
    else if (DEBUG_ADDR_INC_EN) m_addr = m_addr + 16'd2;
    if (DEBUG_LD_DATA_EN) m_data = MEM_DATA_IN;
    e.addr = m_addr; e.arg = m_arg; e.data = m_data;
    e.brk  = (m_mode == 1);
    e.idx  = 3'(m_idx);
    e.st   = 2'(m_mode);
    exp_q.push_back(e);
  endtask

  task automatic clear_inputs();
    DEBUG_ADDR_INC_EN = 0; DEBUG_LD_DATA_EN = 0; DEBUG_LD_ARG_EN = 0;
    DEBUG_LD_BKP_EN = 0; BKP_CLR = 0; CPU_FETCH = 0; CPU_HALTED = 0;
    RESUME = 0; STEP = 0;
  endtask

  // Called at a negedge with inputs set; returns at the next negedge.
  task automatic tick();
    model_step();
    @(negedge CLK);
    clear_inputs();
  endtask

  task automatic ld_arg(input logic [15:0] v);
    DEBUG_LD_ARG_EN = 1; HOST_ARG_IN = v; tick();
  endtask
  task automatic inc();    DEBUG_ADDR_INC_EN = 1; tick(); endtask
  task automatic halt();   CPU_HALTED = 1; tick(); endtask
  task automatic resume(); RESUME = 1; tick(); endtask
  task automatic fetch(input logic [15:0] pc);
    CPU_FETCH = 1; CPU_PC = pc; tick();
  endtask
  task automatic wr_bkp(input logic [15:0] v);
    ld_arg(v); DEBUG_LD_BKP_EN = 1; tick();
  endtask

  task automatic do_reset();
    RESET = 1;
    #1;
    cmp("rst_break_req", 16'(BREAK_REQ), 16'h0);
    cmp("rst_state", 16'(DBG_STATE), 16'h0);
    cmp("rst_addr", DBG_ADDR, 16'h0);
    model_reset();
    @(negedge CLK);
    RESET = 0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge CLK);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        cmp("sb_addr", DBG_ADDR, e.addr);
        cmp("sb_arg", DBG_ARG, e.arg);
        cmp("sb_data", DBG_DATA, e.data);
        cmp("sb_break_req", 16'(BREAK_REQ), 16'(e.brk));
        cmp("sb_hit_idx", 16'(BKP_HIT_IDX), 16'(e.idx));
        cmp("sb_state", 16'(DBG_STATE), 16'(e.st));
      end
    end
  end

  initial begin : stim
    HOST_ARG_IN = 0; MEM_DATA_IN = 0; CPU_PC = 0;
    clear_inputs();
    do_reset();

    ld_arg(16'h1234); inc(); inc(); inc();
    cmp("addr_inc3", DBG_ADDR, 16'h123A);
    cmp("arg_kept", DBG_ARG, 16'h1234);
    ld_arg(16'hFFFE); inc();
    cmp("addr_wrap", DBG_ADDR, 16'h0000);
    DEBUG_LD_ARG_EN = 1; DEBUG_ADDR_INC_EN = 1; HOST_ARG_IN = 16'h0100; tick();
    cmp("ld_over_inc", DBG_ADDR, 16'h0100);
    DEBUG_LD_DATA_EN = 1; MEM_DATA_IN = 16'hBEEF; tick();
    cmp("ld_data", DBG_DATA, 16'hBEEF);

    wr_bkp(16'h0040); wr_bkp(16'h0080); fetch(16'h0080);
    cmp("bkp_break", 16'(BREAK_REQ), 16'h1);
    cmp("bkp_idx", 16'(BKP_HIT_IDX), 16'h1);
    resume();
    cmp("resume_in_break_ignored", 16'(DBG_STATE), 16'h1);
    halt();
    cmp("halt_drop_req", 16'(BREAK_REQ), 16'h0);
    cmp("halt_state", 16'(DBG_STATE), 16'h2);
    fetch(16'h0040);
    cmp("halted_ignores_hit", 16'(DBG_STATE), 16'h2);
    resume(); fetch(16'h0080);
    cmp("stepover_exempt", 16'(BREAK_REQ), 16'h0);
    fetch(16'h0080);
    cmp("rebreak", 16'(BREAK_REQ), 16'h1);
    halt(); resume(); fetch(16'h0200);

    BKP_CLR = 1; tick();
    wr_bkp(16'h0010); wr_bkp(16'h0020); wr_bkp(16'h0030); wr_bkp(16'h0040); wr_bkp(16'h0050);
    fetch(16'h0010);
    cmp("overwritten_slot0", 16'(BREAK_REQ), 16'h0);
    fetch(16'h0050);
    cmp("slot0_new", 16'(BKP_HIT_IDX), 16'h0);
    halt(); resume(); fetch(16'h0300);
    BKP_CLR = 1; DEBUG_LD_BKP_EN = 1; tick();
    fetch(16'h0050);
    cmp("clr_no_break", 16'(BREAK_REQ), 16'h0);

    ld_arg(16'h0070);
    DEBUG_LD_BKP_EN = 1; CPU_FETCH = 1; CPU_PC = 16'h0070; tick();
    cmp("same_cycle_write", 16'(BREAK_REQ), 16'h0);
    fetch(16'h0070);
    cmp("next_cycle_match", 16'(BREAK_REQ), 16'h1);
    do_reset();
    fetch(16'h0070);
    cmp("post_reset_invalid", 16'(BREAK_REQ), 16'h0);

`ifdef DEBUG_SINGLE_STEP_EN
    wr_bkp(16'h0090); fetch(16'h0090); halt();
    STEP = 1; tick();
    fetch(16'h0090);
    cmp("step_exempt", 16'(BREAK_REQ), 16'h0);
    fetch(16'h0094);
    cmp("step_break", 16'(BREAK_REQ), 16'h1);
    cmp("step_idx", 16'(BKP_HIT_IDX), 16'h7);
    halt();
    STEP = 1; RESUME = 1; tick();
    fetch(16'h0090); fetch(16'h0094);
    cmp("resume_beats_step", 16'(BREAK_REQ), 16'h0);
`endif

    for (int n = 0; n < 400; n++) begin
      logic [15:0] pool [4];
      pool[0] = 16'h0040; pool[1] = 16'h0080; pool[2] = 16'h0100; pool[3] = 16'h0200;
      DEBUG_LD_ARG_EN   = ($urandom_range(0, 99) < 30);
      DEBUG_ADDR_INC_EN = ($urandom_range(0, 99) < 30);
      DEBUG_LD_DATA_EN  = ($urandom_range(0, 99) < 30);
      DEBUG_LD_BKP_EN   = ($urandom_range(0, 99) < 15);
      BKP_CLR           = ($urandom_range(0, 99) < 3);
      HOST_ARG_IN = ($urandom_range(0, 9) == 0) ? 16'($urandom) : pool[$urandom_range(0, 3)];
      MEM_DATA_IN = 16'($urandom);
      CPU_FETCH   = ($urandom_range(0, 99) < 50);
      CPU_PC      = pool[$urandom_range(0, 3)];
      CPU_HALTED  = ($urandom_range(0, 99) < 30);
      RESUME      = ($urandom_range(0, 99) < 20);
`ifdef DEBUG_SINGLE_STEP_EN
      STEP        = ($urandom_range(0, 99) < 15);
`endif
      tick();
    end

    repeat (3) @(negedge CLK);
    cmp("queue_drained", 16'(exp_q.size()), 16'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
